// File: rtl/fb_writer.sv
// Framebuffer write feeder: buffers host pixel commands in a FIFO and turns them into
// single-cycle byte writes (addressed writes and colour fills). Optional macro FB_WRITER_VBLANK_ONLY_EN.
module fb_writer #(
    parameter int PIXEL_COUNT = 76800,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        inp_clock,
    input  logic        inp_reset,
    input  logic        inp_cmd_valid,
    output logic        out_cmd_ready,
    input  logic [1:0]  inp_cmd_op,
    input  logic [16:0] inp_cmd_arg,
    input  logic        inp_display_active,
    output logic        out_wr_enable,
    output logic [16:0] out_wr_address,
    output logic [7:0]  out_wr_data,
    output logic        out_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [16:0]      PIX_CNT   = 17'(PIXEL_COUNT);
    localparam logic [16:0]      LAST_ADDR = 17'(PIXEL_COUNT - 1);

    localparam logic [1:0] OP_SET_ADDR  = 2'd0;
    localparam logic [1:0] OP_WRITE     = 2'd1;
    localparam logic [1:0] OP_SET_COLOR = 2'd2;
    localparam logic [1:0] OP_FILL      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    function automatic logic [16:0] wrap_inc(input logic [16:0] a);
        if (a == LAST_ADDR) begin
            return 17'd0;
        end else begin
            return a + 17'd1;
        end
    endfunction

    logic [18:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t      state_q, state_d;
    logic [18:0] cmd_q, cmd_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  colour_q, colour_d;
    logic [16:0] remaining_q, remaining_d;
    logic        wr_en_q, wr_en_d;
    logic [16:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic        push_s, pop_s, write_ok_s;
    logic [1:0]  cmd_op_s;
    logic [16:0] cmd_arg_s;

`ifdef FB_WRITER_VBLANK_ONLY_EN
    assign write_ok_s = ~inp_display_active;
`else
    logic unused_display_s;
    assign unused_display_s = inp_display_active;
    assign write_ok_s       = 1'b1;
`endif

    // Ready is held low during reset so nothing can be accepted while the FIFO is being cleared.
    assign out_cmd_ready = inp_reset & (count_q != FULL_CNT);
    assign push_s        = inp_cmd_valid & out_cmd_ready;
    assign pop_s         = (state_q == ST_IDLE) & (count_q != '0);
    assign cmd_op_s      = cmd_q[18:17];
    assign cmd_arg_s     = cmd_q[16:0];

    assign out_wr_enable  = wr_en_q;
    assign out_wr_address = wr_addr_q;
    assign out_wr_data    = wr_data_q;
    assign out_busy       = (count_q != '0) | (state_q != ST_IDLE);

    // FIFO storage; contents are only meaningful between the pointers, so no reset needed.
    always_ff @(posedge inp_clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {inp_cmd_op, inp_cmd_arg};
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register: FIFO control, engine state and registered write port.
    always_ff @(posedge inp_clock or negedge inp_reset) begin
        if (!inp_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            cmd_q       <= 19'd0;
            addr_q      <= 17'd0;
            colour_q    <= 8'd0;
            remaining_q <= 17'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 17'd0;
            wr_data_q   <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            colour_q    <= colour_d;
            remaining_q <= remaining_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Engine next-state: decode popped command, advance address, count down fills.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        colour_d    = colour_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    cmd_d   = mem_q[rd_ptr_q];
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (cmd_op_s)
                    OP_SET_ADDR: begin
                        addr_d  = (cmd_arg_s < PIX_CNT) ? cmd_arg_s : 17'd0;
                        state_d = ST_IDLE;
                    end
                    OP_WRITE: begin
                        if (write_ok_s) begin
                            addr_d  = wrap_inc(addr_q);
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_SET_COLOR: begin
                        colour_d = cmd_arg_s[7:0];
                        state_d  = ST_IDLE;
                    end
                    OP_FILL: begin
                        if (cmd_arg_s == 17'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            remaining_d = cmd_arg_s;
                            state_d     = ST_FILL;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_FILL: begin
                if (write_ok_s) begin
                    addr_d      = wrap_inc(addr_q);
                    remaining_d = remaining_q - 17'd1;
                    if (remaining_q == 17'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-port next values; address/data hold their last value between strobes.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_EXEC: begin
                if ((cmd_op_s == OP_WRITE) && write_ok_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = cmd_arg_s[7:0];
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (write_ok_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = colour_q;
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            default: wr_en_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: stimulus pushes expected writes, a negedge monitor checks strobes.
module tb_fb_writer;

    logic        inp_clock;
    logic        inp_reset;
    logic        inp_cmd_valid;
    logic        out_cmd_ready;
    logic [1:0]  inp_cmd_op;
    logic [16:0] inp_cmd_arg;
    logic        inp_display_active;
    logic        out_wr_enable;
    logic [16:0] out_wr_address;
    logic [7:0]  out_wr_data;
    logic        out_busy;

    fb_writer #(.PIXEL_COUNT(76800), .FIFO_DEPTH(8)) dut (
        .inp_clock          (inp_clock),
        .inp_reset          (inp_reset),
        .inp_cmd_valid      (inp_cmd_valid),
        .out_cmd_ready      (out_cmd_ready),
        .inp_cmd_op         (inp_cmd_op),
        .inp_cmd_arg        (inp_cmd_arg),
        .inp_display_active (inp_display_active),
        .out_wr_enable      (out_wr_enable),
        .out_wr_address     (out_wr_address),
        .out_wr_data        (out_wr_data),
        .out_busy           (out_busy)
    );

    initial inp_clock = 1'b0;
    always #5 inp_clock = ~inp_clock;

    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   strobe_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_push(input int a, input int d);
        exp_t e;
        e.a = 17'(a);
        e.d = 8'(d);
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge inp_clock) begin
        if (out_wr_enable) begin
            exp_t e;
            strobe_cnt++;
            check("addr_in_range", 32'(out_wr_address < 17'd76800), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got addr %0d data 0x%0h, expected no write",
                         out_wr_address, out_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_address", 32'(out_wr_address), 32'(e.a));
                check("wr_data", 32'(out_wr_data), 32'(e.d));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input logic [1:0] op, input int arg);
        int t;
        t = 0;
        inp_cmd_valid = 1'b1;
        inp_cmd_op    = op;
        inp_cmd_arg   = 17'(arg);
        while (!out_cmd_ready && t < 2000) begin
            @(posedge inp_clock);
            #1;
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got ready=0 for %0d cycles, expected acceptance", t);
        end else begin
            @(posedge inp_clock);
            #1;
        end
        inp_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while ((out_busy || exp_q.size() != 0) && t < bound) begin
            @(posedge inp_clock);
            #1;
            t++;
        end
        check("drain_done", 32'(t < bound), 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int bound);
        int t;
        t = 0;
        while (strobe_cnt < target && t < bound) begin
            @(negedge inp_clock);
            #1;
            t++;
        end
        check("strobe_wait", 32'(strobe_cnt >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int c0;
        inp_reset          = 1'b0;
        inp_cmd_valid      = 1'b0;
        inp_cmd_op         = 2'd0;
        inp_cmd_arg        = 17'd0;
        inp_display_active = 1'b0;

        // Test 1: reset state
        repeat (5) @(negedge inp_clock);
        check("rst_wr_enable", 32'(out_wr_enable), 32'd0);
        check("rst_wr_address", 32'(out_wr_address), 32'd0);
        check("rst_wr_data", 32'(out_wr_data), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        check("rst_ready", 32'(out_cmd_ready), 32'd0);
        @(posedge inp_clock);
        #1 inp_reset = 1'b1;
        @(negedge inp_clock);
        check("post_rst_ready", 32'(out_cmd_ready), 32'd1);
        check("post_rst_busy", 32'(out_busy), 32'd0);
        @(posedge inp_clock);
        #1;

        // Test 2: addressed writes with auto-increment, then latency of a lone WRITE
        exp_push(100, 8'h2A);
        exp_push(101, 8'h2B);
        push(2'd0, 100);
        push(2'd1, 8'h2A);
        push(2'd1, 8'h2B);
        wait_idle(100);
        exp_push(102, 8'h2C);
        push(2'd1, 8'h2C);
        @(negedge inp_clock);
        check("lat_n_busy", 32'(out_busy), 32'd1);
        check("lat_n_en", 32'(out_wr_enable), 32'd0);
        @(negedge inp_clock);
        check("lat_n1_en", 32'(out_wr_enable), 32'd0);
        @(negedge inp_clock);
        check("lat_n2_en", 32'(out_wr_enable), 32'd1);
        @(posedge inp_clock);
        #1;
        wait_idle(100);

        // Test 3: fill across the address wrap
        exp_push(76799, 8'h11);
        exp_push(0, 8'h11);
        exp_push(1, 8'h11);
        base = strobe_cnt;
        push(2'd0, 76799);
        push(2'd2, 8'h11);
        push(2'd3, 3);
        wait_strobes(base + 1, 50);
        @(negedge inp_clock);
        check("fill_consec_2", 32'(out_wr_enable), 32'd1);
        @(negedge inp_clock);
        check("fill_consec_3", 32'(out_wr_enable), 32'd1);
        check("fill_end_busy", 32'(out_busy), 32'd0);
        @(negedge inp_clock);
        check("fill_end_en", 32'(out_wr_enable), 32'd0);
        @(posedge inp_clock);
        #1;

        // Test 4: FIFO fills behind a long FILL; out-of-range SET_ADDR maps to 0
        for (int i = 0; i < 1000; i++) exp_push(200 + i, 8'h33);
        for (int i = 0; i < 8; i++) exp_push(1200 + i, 8'h40 + i);
        exp_push(0, 8'h55);
        push(2'd0, 200);
        push(2'd2, 8'h33);
        push(2'd3, 1000);
        for (int i = 0; i < 8; i++) push(2'd1, 8'h40 + i);
        check("full_ready", 32'(out_cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge inp_clock);
            check("full_ready_hold", 32'(out_cmd_ready), 32'd0);
        end
        @(posedge inp_clock);
        #1;
        push(2'd0, 80000);
        push(2'd1, 8'h55);
        wait_idle(3000);

        // Test 5: FILL 0 is a no-op; reset mid-fill aborts after exactly 20 strobes
        for (int i = 0; i < 20; i++) exp_push(500 + i, 8'h33);
        base = strobe_cnt;
        push(2'd0, 500);
        push(2'd3, 0);
        push(2'd3, 50);
        wait_strobes(base + 20, 200);
        inp_reset = 1'b0;
        repeat (3) @(negedge inp_clock);
        check("abort_en", 32'(out_wr_enable), 32'd0);
        check("abort_busy", 32'(out_busy), 32'd0);
        check("abort_count", 32'(strobe_cnt - base), 32'd20);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        @(posedge inp_clock);
        #1 inp_reset = 1'b1;
        @(negedge inp_clock);
        check("abort_ready", 32'(out_cmd_ready), 32'd1);
        check("abort_busy2", 32'(out_busy), 32'd0);
        @(posedge inp_clock);
        #1;
        exp_push(0, 8'h00);
        exp_push(1, 8'h00);
        push(2'd3, 2);
        wait_idle(100);

        // Test 6: display_active raised mid-fill
        for (int i = 0; i < 10; i++) exp_push(1000 + i, 8'h00);
        base = strobe_cnt;
        push(2'd0, 1000);
        push(2'd3, 10);
        wait_strobes(base + 3, 100);
        @(posedge inp_clock);
        #1 inp_display_active = 1'b1;
        c0 = strobe_cnt;
        repeat (4) @(posedge inp_clock);
        #1;
`ifdef FB_WRITER_VBLANK_ONLY_EN
        check("stall_strobes", 32'(strobe_cnt - c0), 32'd1);
`else
        check("no_stall_strobes", 32'(strobe_cnt - c0), 32'd4);
`endif
        inp_display_active = 1'b0;
        wait_idle(100);
        check("fill10_count", 32'(strobe_cnt - base), 32'd10);

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
